// File: rtl/regmst_pkg.sv
// Shared types and constants for the register-tree master bridge.
package regmst_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } regmst_state_e;

endpackage

// File: rtl/regmst_timeout_cnt.sv
// Access supervision counter: counts enabled cycles and flags the last
// permitted cycle so the bridge can abandon a silent downstream slave.
module regmst_timeout_cnt
    import regmst_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_1,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (enable) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // The increment in this cycle would bring the count to TIMEOUT_CYCLES.
    assign expired = enable && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/apb_regmst_reg_top.sv
// APB-to-reg_native bridge for the register top: forwards every access to
// reg_block_1 unchanged and supervises it with a timeout.
module apb_regmst_reg_top
    import regmst_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  reg_top__reg_block_1_req_vld,
    output logic                  reg_top__reg_block_1_wr_en,
    output logic                  reg_top__reg_block_1_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_top__reg_block_1_addr,
    output logic [DATA_WIDTH-1:0] reg_top__reg_block_1_wr_data,
    input  logic                  reg_top__reg_block_1_ack_vld,
    input  logic [DATA_WIDTH-1:0] reg_top__reg_block_1_rd_data,
    input  logic                  clear,
    output logic                  interrupt,
    output logic                  soft_rst_o
);

    regmst_state_e state_reg, state_next;

    logic                  req_vld_reg, req_vld_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  rd_en_reg, rd_en_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  pready_reg, pready_next;
    logic                  pslverr_reg, pslverr_next;
    logic [DATA_WIDTH-1:0] prdata_reg, prdata_next;
    logic                  interrupt_reg, interrupt_next;
    logic                  soft_rst_reg, soft_rst_next;
    logic                  timeout_evt;
    logic                  wait_active;
    logic                  expired;

    assign wait_active = (state_reg == WAIT);

    regmst_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_1  (PCLK),
        .rst_n  (PRESETn),
        .clear  (!wait_active),
        .enable (wait_active),
        .expired(expired)
    );

    always_comb begin
        state_next     = state_reg;
        req_vld_next   = 1'b0;
        wr_en_next     = wr_en_reg;
        rd_en_next     = rd_en_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        pready_next    = 1'b0;
        pslverr_next   = 1'b0;
        prdata_next    = prdata_reg;
        soft_rst_next  = 1'b0;
        timeout_evt    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Only a setup phase starts an access; the trailing
                // PSEL&PENABLE cycle after completion is ignored.
                if (PSEL && !PENABLE) begin
                    state_next   = REQ;
                    req_vld_next = 1'b1;
                    wr_en_next   = PWRITE;
                    rd_en_next   = !PWRITE;
                    addr_next    = PADDR;
                    wdata_next   = PWDATA;
                end
            end
            REQ, WAIT: begin
                if (reg_top__reg_block_1_ack_vld) begin
                    state_next  = RESP;
                    pready_next = 1'b1;
                    wr_en_next  = 1'b0;
                    rd_en_next  = 1'b0;
                    if (rd_en_reg) begin
                        prdata_next = reg_top__reg_block_1_rd_data;
                    end
                end else if (expired) begin
                    state_next    = RESP;
                    pready_next   = 1'b1;
                    pslverr_next  = 1'b1;
                    soft_rst_next = 1'b1;
                    timeout_evt   = 1'b1;
                    wr_en_next    = 1'b0;
                    rd_en_next    = 1'b0;
                end else begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new timeout outranks a simultaneous clear.
        interrupt_next = timeout_evt | (interrupt_reg & ~clear);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            req_vld_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            pready_reg    <= 1'b0;
            pslverr_reg   <= 1'b0;
            prdata_reg    <= '0;
            interrupt_reg <= 1'b0;
            soft_rst_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_vld_reg   <= req_vld_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            pready_reg    <= pready_next;
            pslverr_reg   <= pslverr_next;
            prdata_reg    <= prdata_next;
            interrupt_reg <= interrupt_next;
            soft_rst_reg  <= soft_rst_next;
        end
    end

    assign PREADY                       = pready_reg;
    assign PSLVERR                      = pslverr_reg;
    assign PRDATA                       = prdata_reg;
    assign reg_top__reg_block_1_req_vld = req_vld_reg;
    assign reg_top__reg_block_1_wr_en   = wr_en_reg;
    assign reg_top__reg_block_1_rd_en   = rd_en_reg;
    assign reg_top__reg_block_1_addr    = addr_reg;
    assign reg_top__reg_block_1_wr_data = wdata_reg;
    assign interrupt                    = interrupt_reg;
    assign soft_rst_o                   = soft_rst_reg;

endmodule

// File: tb/tb_apb_regmst_reg_top.sv
// Directed self-checking bench for apb_regmst_reg_top.
module tb_apb_regmst_reg_top;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 24;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic          req_vld;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld;
    logic [DW-1:0] rd_data;
    logic          clear;
    logic          interrupt;
    logic          soft_rst_o;

    int checks = 0;
    int errors = 0;

    apb_regmst_reg_top #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK                        (PCLK),
        .PRESETn                     (PRESETn),
        .PSEL                        (PSEL),
        .PENABLE                     (PENABLE),
        .PWRITE                      (PWRITE),
        .PADDR                       (PADDR),
        .PWDATA                      (PWDATA),
        .PREADY                      (PREADY),
        .PRDATA                      (PRDATA),
        .PSLVERR                     (PSLVERR),
        .reg_top__reg_block_1_req_vld(req_vld),
        .reg_top__reg_block_1_wr_en  (wr_en),
        .reg_top__reg_block_1_rd_en  (rd_en),
        .reg_top__reg_block_1_addr   (addr),
        .reg_top__reg_block_1_wr_data(wr_data),
        .reg_top__reg_block_1_ack_vld(ack_vld),
        .reg_top__reg_block_1_rd_data(rd_data),
        .clear                       (clear),
        .interrupt                   (interrupt),
        .soft_rst_o                  (soft_rst_o)
    );

    always #5 PCLK = ~PCLK;

    // APB master plus downstream responder; ack_lat < 0 means never ack.
    // lat = cycles from the req_vld cycle to the PREADY cycle (-1 if none).
    task automatic apb_xfer(
        input  logic          wr,
        input  logic [AW-1:0] a,
        input  logic [DW-1:0] wd,
        input  int            ack_lat,
        input  logic [DW-1:0] resp,
        input  logic          hold_trail,
        output logic [DW-1:0] rdata,
        output logic          err,
        output int            nreq,
        output int            lat,
        output logic [AW-1:0] q_addr,
        output logic [DW-1:0] q_wdata,
        output logic          q_wr,
        output logic          q_rd,
        output logic          stable,
        output logic          intr,
        output logic          srst,
        output logic          spurious
    );
        logic done;
        rdata = '0; err = 1'b0; nreq = 0; lat = -1; q_addr = '0; q_wdata = '0;
        q_wr = 1'b0; q_rd = 1'b0; stable = 1'b1; intr = 1'b0; srst = 1'b0;
        spurious = 1'b0; done = 1'b0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) @(negedge PCLK);
            if (PREADY) begin
                done = 1'b1; lat = c; rdata = PRDATA; err = PSLVERR;
                intr = interrupt; srst = soft_rst_o;
                ack_vld = 1'b0;
            end else begin
                if (req_vld) begin
                    nreq++; q_addr = addr; q_wdata = wr_data; q_wr = wr_en; q_rd = rd_en;
                end else if (nreq > 0 && (addr != q_addr || wr_data != q_wdata ||
                                          wr_en != q_wr || rd_en != q_rd)) begin
                    stable = 1'b0;
                end
                ack_vld = (c == ack_lat);
                rd_data = (c == ack_lat) ? resp : 32'hDEAD_BEEF;
            end
        end
        ack_vld = 1'b0;
        if (hold_trail) begin
            @(negedge PCLK);
            if (req_vld) spurious = 1'b1;
            @(negedge PCLK);
            if (req_vld) spurious = 1'b1;
            PSEL = 1'b0; PENABLE = 1'b0;
        end
        $display("xfer wr=%0d addr=%h wdata=%h ack_lat=%0d lat=%0d rdata=%h err=%0d nreq=%0d",
                 wr, a, wd, ack_lat, lat, rdata, err, nreq);
    endtask

    logic [DW-1:0] t_rdata, t_qwdata;
    logic [AW-1:0] t_qaddr;
    logic          t_err, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur;
    int            t_nreq, t_lat;

    task automatic test_reset();
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ack_vld = 1'b0; rd_data = '0; clear = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++;
        if ({PREADY, PSLVERR, req_vld, wr_en, rd_en, interrupt, soft_rst_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {PREADY, PSLVERR, req_vld, wr_en, rd_en, interrupt, soft_rst_o});
        end
        checks++;
        if (addr !== 64'h0 || wr_data !== 32'h0) begin
            errors++; $display("FAIL reset_req_bus got addr=%h wdata=%h exp 0", addr, wr_data);
        end
        checks++;
        if (PRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_prdata got %h exp 0", PRDATA);
        end
        PRESETn = 1'b1;
    endtask

    task automatic test_write();
        apb_xfer(1'b1, 64'h4, 32'h1111_1111, 3, 32'h0, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if (t_nreq !== 1) begin errors++; $display("FAIL wr_nreq got %0d exp 1", t_nreq); end
        checks++;
        if ({t_qwr, t_qrd} !== 2'b10) begin
            errors++; $display("FAIL wr_enables got %b exp 10", {t_qwr, t_qrd});
        end
        checks++;
        if (t_qaddr !== 64'h4 || t_qwdata !== 32'h1111_1111) begin
            errors++; $display("FAIL wr_fields got %h/%h exp 4/11111111", t_qaddr, t_qwdata);
        end
        checks++;
        if (t_lat !== 4 || t_err !== 1'b0) begin
            errors++; $display("FAIL wr_resp got lat=%0d err=%0d exp lat=4 err=0", t_lat, t_err);
        end
        checks++;
        if (t_stable !== 1'b1) begin errors++; $display("FAIL wr_stable got 0 exp 1"); end
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin errors++; $display("FAIL wr_pready_width got 1 exp 0"); end
    endtask

    task automatic test_read();
        apb_xfer(1'b0, 64'h8, 32'h0, 2, 32'h2222_2222, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if ({t_qwr, t_qrd} !== 2'b01 || t_nreq !== 1) begin
            errors++; $display("FAIL rd_req got en=%b nreq=%0d exp en=01 nreq=1", {t_qwr, t_qrd}, t_nreq);
        end
        checks++;
        if (t_rdata !== 32'h2222_2222 || t_lat !== 3 || t_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got %h lat=%0d err=%0d exp 22222222 lat=3 err=0", t_rdata, t_lat, t_err);
        end
        // Following write acked with unrelated data must not disturb PRDATA.
        apb_xfer(1'b1, 64'hC, 32'h3333_3333, 1, 32'h5555_5555, 1'b1, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if (PRDATA !== 32'h2222_2222) begin
            errors++; $display("FAIL rd_hold got %h exp 22222222", PRDATA);
        end
        checks++;
        if (t_spur !== 1'b0) begin errors++; $display("FAIL rd_trailing got spurious req exp none"); end
    endtask

    task automatic test_ack_in_req();
        apb_xfer(1'b0, 64'h10, 32'h0, 0, 32'hA5A5_0F0F, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if (t_lat !== 1) begin errors++; $display("FAIL ackreq_lat got %0d exp 1", t_lat); end
        checks++;
        if (t_rdata !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL ackreq_data got %h exp a5a50f0f", t_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int lat_tab [16] = '{1, 20, 3, 7, 2, 15, 1, 9, 4, 1, 20, 6, 11, 2, 18, 5};
        logic [DW-1:0] exp_prdata;
        logic [AW-1:0] a;
        logic [DW-1:0] resp;
        logic          wr;
        exp_prdata = 32'hA5A5_0F0F;
        for (int i = 0; i < 16; i++) begin
            wr   = (i < 8);
            a    = 64'h1000 + 64'(i * 8);
            resp = 32'hB000_0000 + 32'(i);
            apb_xfer(wr, a, 32'hC0DE_0000 + 32'(i), lat_tab[i], resp, (i % 4) == 3,
                     t_rdata, t_err, t_nreq, t_lat, t_qaddr, t_qwdata, t_qwr, t_qrd,
                     t_stable, t_intr, t_srst, t_spur);
            if (!wr) exp_prdata = resp;
            checks++;
            if (t_nreq !== 1 || t_qaddr !== a) begin
                errors++; $display("FAIL b2b_req[%0d] got nreq=%0d addr=%h exp 1/%h", i, t_nreq, t_qaddr, a);
            end
            checks++;
            if (t_lat !== lat_tab[i] + 1) begin
                errors++; $display("FAIL b2b_lat[%0d] got %0d exp %0d", i, t_lat, lat_tab[i] + 1);
            end
            checks++;
            if (t_rdata !== exp_prdata) begin
                errors++; $display("FAIL b2b_prdata[%0d] got %h exp %h", i, t_rdata, exp_prdata);
            end
            if ((i % 4) == 3) begin
                checks++;
                if (t_spur !== 1'b0) begin
                    errors++; $display("FAIL b2b_trailing[%0d] got spurious req exp none", i);
                end
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_timeout();
        clear = 1'b0;
        apb_xfer(1'b1, 64'h2000, 32'hDEAD_0001, -1, 32'h0, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if (t_lat < TO || t_lat > TO + 2 || t_err !== 1'b1) begin
            errors++; $display("FAIL to_resp got lat=%0d err=%0d exp lat=%0d..%0d err=1", t_lat, t_err, TO, TO + 2);
        end
        checks++;
        if (t_srst !== 1'b1 || t_intr !== 1'b1) begin
            errors++; $display("FAIL to_side got srst=%0d intr=%0d exp 1/1", t_srst, t_intr);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        checks++;
        if (soft_rst_o !== 1'b0 || PREADY !== 1'b0) begin
            errors++; $display("FAIL to_pulse got srst=%0d pready=%0d exp 0/0", soft_rst_o, PREADY);
        end
        repeat (5) @(negedge PCLK);
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL to_sticky got 0 exp 1"); end
        clear = 1'b1;
        @(negedge PCLK);
        clear = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL to_clear got 1 exp 0"); end
        // Clear held high through a second timeout.
        clear = 1'b1;
        apb_xfer(1'b0, 64'h2008, 32'h0, -1, 32'h0, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        clear = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        checks++;
        if (t_intr !== 1'b1 || t_err !== 1'b1) begin
            errors++; $display("FAIL to_clear_coincide got intr=%0d err=%0d exp 1/1", t_intr, t_err);
        end
        @(negedge PCLK);
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL to_after_coincide got 0 exp 1"); end
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 64'h3000;
        @(negedge PCLK);
        PENABLE = 1'b1;
        repeat (3) @(negedge PCLK);
        checks++;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got rd_en=0 exp 1"); end
        PRESETn = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({PREADY, PSLVERR, req_vld, wr_en, rd_en, interrupt, soft_rst_o} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got %b exp 0000000",
                     {PREADY, PSLVERR, req_vld, wr_en, rd_en, interrupt, soft_rst_o});
        end
        checks++;
        if (addr !== 64'h0 || wr_data !== 32'h0 || PRDATA !== 32'h0) begin
            errors++; $display("FAIL rstmid_data got %h/%h/%h exp 0/0/0", addr, wr_data, PRDATA);
        end
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        apb_xfer(1'b1, 64'h40, 32'h600D_600D, 2, 32'h0, 1'b0, t_rdata, t_err, t_nreq, t_lat,
                 t_qaddr, t_qwdata, t_qwr, t_qrd, t_stable, t_intr, t_srst, t_spur);
        checks++;
        if (t_lat !== 3 || t_err !== 1'b0 || t_nreq !== 1 || t_qwdata !== 32'h600D_600D) begin
            errors++;
            $display("FAIL rstmid_next got lat=%0d err=%0d nreq=%0d wd=%h exp 3/0/1/600d600d",
                     t_lat, t_err, t_nreq, t_qwdata);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ack_in_req();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
